// File: rtl/clock_set_ctrl.sv
// Hour/minute/second timekeeper with key-driven field setting and auto-return to RUN.
// Long press walks through the set modes; short press edits the selected field.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned HOUR_MAX  = 23
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [1:0] key_state,
  input  logic       tick_1hz,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } mode_e;

  localparam logic [4:0] HOUR_MAX_L = 5'(HOUR_MAX);
  localparam logic [5:0] TIMEOUT_L  = 6'(TIMEOUT_S);

  mode_e      mode_q, mode_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] minute_q, minute_d;
  logic [5:0] second_q, second_d;
  logic       blink_q, blink_d;
  logic [5:0] cnt_q, cnt_d;

  logic       short_s, long_s;
  logic [5:0] cnt_inc_s;
  mode_e      mode_next_s;

  assign short_s   = (key_state == 2'b01);
  assign long_s    = (key_state == 2'b10);
  assign cnt_inc_s = cnt_q + 6'd1;

  // Successor mode for a long press
  always_comb begin
    case (mode_q)
      RUN:      mode_next_s = SET_HOUR;
      SET_HOUR: mode_next_s = SET_MIN;
      SET_MIN:  mode_next_s = SET_SEC;
      SET_SEC:  mode_next_s = RUN;
      default:  mode_next_s = RUN;
    endcase
  end

  // Next-state computation for time, mode, blink and idle counter
  always_comb begin
    mode_d   = mode_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    blink_d  = blink_q;
    cnt_d    = cnt_q;

    if (mode_q == RUN) begin
      if (tick_1hz) begin
        if (second_q == 6'd59) begin
          second_d = 6'd0;
          if (minute_q == 6'd59) begin
            minute_d = 6'd0;
            hour_d   = (hour_q == HOUR_MAX_L) ? 5'd0 : hour_q + 5'd1;
          end else begin
            minute_d = minute_q + 6'd1;
          end
        end else begin
          second_d = second_q + 6'd1;
        end
      end else begin
        second_d = second_q;
      end
      // Short press has no effect while running; a long press still lets the tick land
      if (long_s) begin
        mode_d  = SET_HOUR;
        blink_d = 1'b1;
      end else begin
        mode_d  = RUN;
        blink_d = 1'b0;
      end
      cnt_d = 6'd0;
    end else begin
      if (tick_1hz) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
      end

      if (short_s || long_s) begin
        cnt_d = 6'd0;
      end else if (tick_1hz) begin
        if (cnt_inc_s == TIMEOUT_L) begin
          mode_d  = RUN;
          blink_d = 1'b0;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end else begin
        cnt_d = cnt_q;
      end

      if (short_s) begin
        case (mode_q)
          SET_HOUR: hour_d   = (hour_q == HOUR_MAX_L) ? 5'd0 : hour_q + 5'd1;
          SET_MIN:  minute_d = (minute_q == 6'd59) ? 6'd0 : minute_q + 6'd1;
          SET_SEC:  second_d = 6'd0;
          default:  second_d = second_q;
        endcase
      end else begin
        second_d = second_d;
      end

      if (long_s) begin
        mode_d  = mode_next_s;
        blink_d = (mode_next_s != RUN);
      end else begin
        mode_d = mode_d;
      end
    end
  end

  // State registers; reset is immediate
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= RUN;
      hour_q   <= 5'd0;
      minute_q <= 6'd0;
      second_q <= 6'd0;
      blink_q  <= 1'b0;
      cnt_q    <= 6'd0;
    end else begin
      mode_q   <= mode_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
      blink_q  <= blink_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hour   = hour_q;
  assign minute = minute_q;
  assign second = second_q;
  assign mode   = mode_q;
  assign blink  = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl: a vector table plus multi-cycle sequences.
module tb_clock_set_ctrl;

  logic       CLOCK_50;
  logic       rst_n;
  logic [1:0] key_state;
  logic       tick_1hz;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic       blink;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_SHORT = 2'b01;
  localparam logic [1:0] K_LONG = 2'b10;
  localparam logic [1:0] K_BAD = 2'b11;

  clock_set_ctrl #(.TIMEOUT_S(10), .HOUR_MAX(23)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .key_state(key_state),
    .tick_1hz (tick_1hz),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .mode     (mode),
    .blink    (blink)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [1:0] key;
    logic       tick;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
    logic       bl;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [4:0] eh, input logic [5:0] em,
                     input logic [5:0] es, input logic [1:0] emd, input logic eb);
    checks++;
    if ({hour, minute, second, mode, blink} !== {eh, em, es, emd, eb}) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
               name, hour, minute, second, mode, blink, eh, em, es, emd, eb);
    end
  endtask

  // One clock with the given inputs; outputs are stable 1 time unit after the edge
  task automatic cyc(input logic [1:0] k, input logic t);
    key_state = k;
    tick_1hz  = t;
    @(posedge CLOCK_50);
    #1;
    key_state = K_NONE;
    tick_1hz  = 1'b0;
  endtask

  task automatic rep(input logic [1:0] k, input logic t, input int n);
    for (int i = 0; i < n; i++) cyc(k, t);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    rst_n = 1'b0;
    @(posedge CLOCK_50);
    #1;
    chk("reset_state", 5'd0, 6'd0, 6'd0, 2'b00, 1'b0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_state = K_NONE;
    tick_1hz  = 1'b0;

    vecs.push_back('{K_NONE,  1'b0, 5'd0, 6'd0, 6'd0, 2'b00, 1'b0});
    vecs.push_back('{K_NONE,  1'b1, 5'd0, 6'd0, 6'd1, 2'b00, 1'b0});
    vecs.push_back('{K_BAD,   1'b1, 5'd0, 6'd0, 6'd2, 2'b00, 1'b0});
    vecs.push_back('{K_SHORT, 1'b1, 5'd0, 6'd0, 6'd3, 2'b00, 1'b0});
    vecs.push_back('{K_LONG,  1'b1, 5'd0, 6'd0, 6'd4, 2'b01, 1'b1});
    vecs.push_back('{K_SHORT, 1'b0, 5'd1, 6'd0, 6'd4, 2'b01, 1'b1});
    vecs.push_back('{K_NONE,  1'b1, 5'd1, 6'd0, 6'd4, 2'b01, 1'b0});
    vecs.push_back('{K_SHORT, 1'b1, 5'd2, 6'd0, 6'd4, 2'b01, 1'b1});
    vecs.push_back('{K_BAD,   1'b0, 5'd2, 6'd0, 6'd4, 2'b01, 1'b1});
    vecs.push_back('{K_LONG,  1'b0, 5'd2, 6'd0, 6'd4, 2'b10, 1'b1});
    vecs.push_back('{K_SHORT, 1'b0, 5'd2, 6'd1, 6'd4, 2'b10, 1'b1});
    vecs.push_back('{K_LONG,  1'b0, 5'd2, 6'd1, 6'd4, 2'b11, 1'b1});
    vecs.push_back('{K_SHORT, 1'b0, 5'd2, 6'd1, 6'd0, 2'b11, 1'b1});
    vecs.push_back('{K_LONG,  1'b0, 5'd2, 6'd1, 6'd0, 2'b00, 1'b0});
    vecs.push_back('{K_NONE,  1'b1, 5'd2, 6'd1, 6'd1, 2'b00, 1'b0});

    do_reset();
    foreach (vecs[i]) begin
      cyc(vecs[i].key, vecs[i].tick);
      chk($sformatf("vec%0d", i), vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].md, vecs[i].bl);
    end

    // Seconds into minutes
    do_reset();
    rep(K_NONE, 1'b1, 59);
    chk("tick59", 5'd0, 6'd0, 6'd59, 2'b00, 1'b0);
    cyc(K_NONE, 1'b1);
    chk("tick60", 5'd0, 6'd1, 6'd0, 2'b00, 1'b0);

    // Preload 23:59:58 and roll over the day
    cyc(K_LONG, 1'b0);
    rep(K_SHORT, 1'b0, 23);
    chk("hour23", 5'd23, 6'd1, 6'd0, 2'b01, 1'b1);
    cyc(K_LONG, 1'b0);
    rep(K_SHORT, 1'b0, 58);
    cyc(K_LONG, 1'b0);
    cyc(K_SHORT, 1'b0);
    cyc(K_LONG, 1'b0);
    chk("preload", 5'd23, 6'd59, 6'd0, 2'b00, 1'b0);
    rep(K_NONE, 1'b1, 58);
    chk("at_235958", 5'd23, 6'd59, 6'd58, 2'b00, 1'b0);
    rep(K_NONE, 1'b1, 2);
    chk("day_wrap", 5'd0, 6'd0, 6'd0, 2'b00, 1'b0);

    // Field wrap while setting
    cyc(K_LONG, 1'b0);
    chk("enter_set_hour", 5'd0, 6'd0, 6'd0, 2'b01, 1'b1);
    rep(K_SHORT, 1'b0, 25);
    chk("hour_wrap", 5'd1, 6'd0, 6'd0, 2'b01, 1'b1);
    cyc(K_LONG, 1'b0);
    chk("enter_set_min", 5'd1, 6'd0, 6'd0, 2'b10, 1'b1);
    rep(K_SHORT, 1'b0, 61);
    chk("minute_wrap", 5'd1, 6'd1, 6'd0, 2'b10, 1'b1);

    // Seconds clear in SET_SEC
    rep(K_LONG, 1'b0, 2);
    rep(K_NONE, 1'b1, 37);
    rep(K_LONG, 1'b0, 3);
    chk("set_sec_37", 5'd1, 6'd1, 6'd37, 2'b11, 1'b1);
    cyc(K_SHORT, 1'b0);
    chk("sec_clear", 5'd1, 6'd1, 6'd0, 2'b11, 1'b1);
    cyc(K_LONG, 1'b0);
    chk("back_to_run", 5'd1, 6'd1, 6'd0, 2'b00, 1'b0);

    // Idle timeout
    cyc(K_LONG, 1'b0);
    rep(K_NONE, 1'b1, 9);
    chk("timeout_t9", 5'd1, 6'd1, 6'd0, 2'b01, 1'b0);
    cyc(K_NONE, 1'b1);
    chk("timeout_t10", 5'd1, 6'd1, 6'd0, 2'b00, 1'b0);
    cyc(K_LONG, 1'b0);
    rep(K_NONE, 1'b1, 9);
    cyc(K_SHORT, 1'b0);
    cyc(K_NONE, 1'b1);
    chk("timeout_restart", 5'd2, 6'd1, 6'd0, 2'b01, 1'b1);

    // Invalid code held
    rep(K_BAD, 1'b0, 5);
    chk("invalid_hold", 5'd2, 6'd1, 6'd0, 2'b01, 1'b1);
    rep(K_LONG, 1'b0, 3);
    chk("run_again", 5'd2, 6'd1, 6'd0, 2'b00, 1'b0);

    // Long press and tick together in RUN
    rep(K_NONE, 1'b1, 5);
    cyc(K_LONG, 1'b1);
    chk("long_plus_tick", 5'd2, 6'd1, 6'd6, 2'b01, 1'b1);

    // Asynchronous reset in SET_MIN
    cyc(K_LONG, 1'b0);
    chk("in_set_min", 5'd2, 6'd1, 6'd6, 2'b10, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 5'd0, 6'd0, 6'd0, 2'b00, 1'b0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(posedge CLOCK_50);
    #1;
    chk("after_reset", 5'd0, 6'd0, 6'd0, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
